irq_sequencer: RTL

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: four-source, edge-triggered interrupt sequencer with PENDING/STATUS bus registers.
// Define IRQ_NESTING_EN to build in nested service backed by a 4-entry return stack.
module irq_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq_sources,
    input  logic [4:0]  irq_mask,
    output logic        irq_req,
    output logic [1:0]  irq_id,
    input  logic        irq_ack,
    input  logic        irq_done,
    output logic [1:0]  active_id,
    output logic        busy,
    inout  wire  [31:0] data_bus_data,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode
);

    localparam int          DATA_W       = 32;
    localparam logic [31:0] ADDR_PENDING = 32'h0000_4010;
    localparam logic [31:0] ADDR_STATUS  = 32'h0000_4011;
    localparam logic [1:0]  MODE_READ    = 2'b01;
    localparam logic [1:0]  MODE_WRITE   = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [3:0]          pending, pending_next;
    logic [3:0]          src_p0;
    logic                first_cycle;
    logic [2:0]          depth, depth_next;
    logic                irq_req_next;
    logic [1:0]          irq_id_next;
    logic [1:0]          active_id_next;
    logic [3:0]          fall, eligible, candidates;
    logic [3:0]          ack_clr, bus_clr;
    logic                ack_take, done_take;
    logic                wr_pending, rd_hit;
    logic [DATA_W-1:0]   status_word, rd_word;
    logic                unused_bus_hi;

    // Highest-index set bit wins; an empty vector yields 0.
    function automatic logic [1:0] highest(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[3])      idx = 2'd3;
        else if (v[2]) idx = 2'd2;
        else if (v[1]) idx = 2'd1;
        return idx;
    endfunction

`ifdef IRQ_NESTING_EN
    logic [1:0] stack [4];
    logic [1:0] top_slot;
    logic       push;

    // Sources that may preempt the given in-service id.
    function automatic logic [3:0] higher_than(input logic [1:0] id);
        logic [3:0] m;
        m = 4'b1110 << id;
        return m;
    endfunction

    assign top_slot = 2'(depth - 3'd1);

    always_ff @(posedge clk) begin
        if (push)
            stack[depth[1:0]] <= active_id;
    end
`endif

    assign busy       = (state == SERVICE);
    assign wr_pending = (data_bus_mode == MODE_WRITE) && (data_bus_addr == ADDR_PENDING);

    always_comb begin
        fall         = first_cycle ? 4'b0000 : (src_p0 & ~irq_sources);
        eligible     = pending & irq_mask[3:0] & {4{irq_mask[4]}};
`ifdef IRQ_NESTING_EN
        candidates   = (state == SERVICE) ? (eligible & higher_than(active_id)) : eligible;
`else
        candidates   = (state == SERVICE) ? 4'b0000 : eligible;
`endif
        done_take    = irq_done && (state == SERVICE);
        // A coincident done is handled first and swallows the ack.
        ack_take     = irq_req && irq_ack && !irq_done;
        ack_clr      = ack_take ? (4'b0001 << irq_id) : 4'b0000;
        bus_clr      = wr_pending ? data_bus_data[3:0] : 4'b0000;
        pending_next = (pending & ~ack_clr & ~bus_clr) | fall;
        irq_req_next = !ack_take && (|candidates);
        irq_id_next  = highest(candidates);

        state_next     = state;
        active_id_next = active_id;
        depth_next     = depth;
`ifdef IRQ_NESTING_EN
        push           = 1'b0;
`endif
        if (done_take) begin
`ifdef IRQ_NESTING_EN
            if (depth != 3'd0) begin
                depth_next     = depth - 3'd1;
                active_id_next = stack[top_slot];
            end else begin
                state_next     = IDLE;
                active_id_next = 2'd0;
            end
`else
            state_next     = IDLE;
            active_id_next = 2'd0;
`endif
        end else if (ack_take) begin
`ifdef IRQ_NESTING_EN
            if (state == SERVICE) begin
                push       = 1'b1;
                depth_next = depth + 3'd1;
            end
`endif
            state_next     = SERVICE;
            active_id_next = irq_id;
        end
    end

    // Stage p0: input sample history plus all sequencer control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= 4'b0000;
            src_p0      <= 4'hF;
            first_cycle <= 1'b1;
            irq_req     <= 1'b0;
            irq_id      <= 2'd0;
            active_id   <= 2'd0;
            depth       <= 3'd0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            src_p0      <= irq_sources;
            first_cycle <= 1'b0;
            irq_req     <= irq_req_next;
            irq_id      <= irq_id_next;
            active_id   <= active_id_next;
            depth       <= depth_next;
        end
    end

    assign status_word   = {25'b0, depth, busy, busy, active_id};
    assign rd_word       = (data_bus_addr == ADDR_PENDING) ? {28'b0, pending} : status_word;
    assign rd_hit        = (data_bus_mode == MODE_READ) &&
                           ((data_bus_addr == ADDR_PENDING) || (data_bus_addr == ADDR_STATUS));
    assign data_bus_data = rd_hit ? rd_word : {DATA_W{1'bz}};
    assign unused_bus_hi = ^data_bus_data[31:4];

endmodule
